// File: rtl/ecb_block_packer.sv
// ecb_block_packer: packs a byte stream into 128-bit AES plaintext blocks with PKCS#7 or zero padding.
module ecb_block_packer #(
    parameter bit PAD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [128:1] blk_data,
    output logic         blk_last,
    output logic [15:0]  blk_count
);
    typedef enum logic {FILL, HOLD} state_t;
    state_t     state;
    logic [3:0] idx;
    logic       pad_pend;

    assign in_ready  = (state == FILL);
    assign blk_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= 4'd0;
            pad_pend  <= 1'b0;
            blk_data  <= '0;
            blk_last  <= 1'b0;
            blk_count <= 16'd0;
        end else if (state == FILL) begin
            if (in_valid) begin
                blk_data[128-8*int'(idx) -: 8] <= in_byte;
                idx <= idx + 4'd1;
                if (idx == 4'd15) begin
                    state    <= HOLD;
                    idx      <= 4'd0;
                    blk_last <= in_last && !PAD_EN;
                    pad_pend <= in_last && PAD_EN;
                end else if (in_last) begin
                    // remaining slots carry the pad count 16-n, where n = idx+1 bytes were received
                    for (int k = 1; k < 16; k++)
                        if (k > int'(idx))
                            blk_data[128-8*k -: 8] <= PAD_EN ? {4'h0, 4'hf - idx} : 8'h00;
                    state    <= HOLD;
                    idx      <= 4'd0;
                    blk_last <= 1'b1;
                end
            end
        end else if (blk_ready) begin
            blk_count <= blk_count + 16'd1;
            if (pad_pend) begin
                blk_data <= {16{8'h10}};
                blk_last <= 1'b1;
                pad_pend <= 1'b0;
            end else begin
                state <= FILL;
            end
        end
    end
endmodule

// File: tb/tb_ecb_block_packer.sv
// tb_ecb_block_packer: directed tests for the block packer, padded and zero-fill variants.
module tb_ecb_block_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_byte = 8'h00;
    logic         in_last = 1'b0;
    logic         blk_ready = 1'b0;
    logic         in_ready, blk_valid, blk_last;
    logic [128:1] blk_data;
    logic [15:0]  blk_count;
    logic         in_ready0, blk_valid0, blk_last0;
    logic [128:1] blk_data0;
    logic [15:0]  blk_count0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ecb_block_packer #(.PAD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .in_last(in_last), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
        .blk_count(blk_count)
    );

    ecb_block_packer #(.PAD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_byte(in_byte), .in_last(in_last), .blk_valid(blk_valid0),
        .blk_ready(blk_ready), .blk_data(blk_data0), .blk_last(blk_last0),
        .blk_count(blk_count0)
    );

    task automatic reset_dut();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic l);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handoff();
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        vectors++;
        if ({in_ready, blk_valid, blk_last, blk_count} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b cnt=%h want 1 0 0 0000", in_ready, blk_valid, blk_last, blk_count);
        end
        vectors++;
        if (blk_data !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", blk_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_block();
        reset_dut();
        for (int i = 0; i < 16; i++) push(8'(i * 17), 1'b0);
        vectors++;
        if ({blk_valid, in_ready, blk_last} !== 3'b100 || blk_data !== 128'h00112233445566778899aabbccddeeff) begin
            miscompares++;
            $display("FAIL full_block: got vld=%b rdy=%b last=%b data=%h want 1 0 0 00112233445566778899aabbccddeeff", blk_valid, in_ready, blk_last, blk_data);
        end
        handoff();
        vectors++;
        if ({in_ready, blk_valid, blk_count} !== {1'b1, 1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL full_handoff: got rdy=%b vld=%b cnt=%h want 1 0 0001", in_ready, blk_valid, blk_count);
        end
    endtask

    task automatic test_exact_multiple();
        reset_dut();
        for (int i = 0; i < 16; i++) push(8'(i * 17), i == 15);
        vectors++;
        if ({blk_valid, blk_last} !== 2'b10 || blk_data !== 128'h00112233445566778899aabbccddeeff) begin
            miscompares++;
            $display("FAIL exact_blk1: got vld=%b last=%b data=%h want 1 0 00112233445566778899aabbccddeeff", blk_valid, blk_last, blk_data);
        end
        handoff();
        vectors++;
        if ({blk_valid, in_ready, blk_last} !== 3'b101 || blk_data !== {16{8'h10}} || blk_count !== 16'd1) begin
            miscompares++;
            $display("FAIL exact_pad_blk: got vld=%b rdy=%b last=%b cnt=%h data=%h want 1 0 1 0001 10..10", blk_valid, in_ready, blk_last, blk_count, blk_data);
        end
        handoff();
        vectors++;
        if ({in_ready, blk_valid, blk_count} !== {1'b1, 1'b0, 16'd2}) begin
            miscompares++;
            $display("FAIL exact_done: got rdy=%b vld=%b cnt=%h want 1 0 0002", in_ready, blk_valid, blk_count);
        end
    endtask

    task automatic test_partial();
        reset_dut();
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b1);
        vectors++;
        if ({blk_valid, blk_last} !== 2'b11 || blk_data !== 128'haabbcc0d0d0d0d0d0d0d0d0d0d0d0d0d) begin
            miscompares++;
            $display("FAIL partial_pkcs7: got vld=%b last=%b data=%h want 1 1 aabbcc0d0d0d0d0d0d0d0d0d0d0d0d0d", blk_valid, blk_last, blk_data);
        end
        vectors++;
        if ({blk_valid0, blk_last0} !== 2'b11 || blk_data0 !== 128'haabbcc00000000000000000000000000) begin
            miscompares++;
            $display("FAIL partial_zero: got vld=%b last=%b data=%h want 1 1 aabbcc00000000000000000000000000", blk_valid0, blk_last0, blk_data0);
        end
        handoff();
        vectors++;
        if ({in_ready, in_ready0, blk_count, blk_count0} !== {2'b11, 16'd1, 16'd1}) begin
            miscompares++;
            $display("FAIL partial_done: got rdy=%b rdy0=%b cnt=%h cnt0=%h want 1 1 0001 0001", in_ready, in_ready0, blk_count, blk_count0);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        for (int i = 0; i < 16; i++) push(8'(i * 17), 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({blk_valid, in_ready} !== 2'b10 || blk_data !== 128'h00112233445566778899aabbccddeeff) begin
                miscompares++;
                $display("FAIL backpressure_hold: cycle %0d got vld=%b rdy=%b data=%h", c, blk_valid, in_ready, blk_data);
            end
        end
        handoff();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i < 16; i++) push(8'(i), 1'b0);
        vectors++;
        if (blk_valid !== 1'b1 || blk_data !== 128'h550102030405060708090a0b0c0d0e0f) begin
            miscompares++;
            $display("FAIL backpressure_next: got vld=%b data=%h want 1 550102030405060708090a0b0c0d0e0f", blk_valid, blk_data);
        end
    endtask

    task automatic test_mid_reset();
        reset_dut();
        for (int i = 0; i < 7; i++) push(8'hFF, 1'b0);
        rst = 1'b1;
        #3;
        vectors++;
        if ({in_ready, blk_valid, blk_last, blk_count} !== {1'b1, 1'b0, 1'b0, 16'h0} || blk_data !== 128'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outs: got rdy=%b vld=%b last=%b cnt=%h data=%h", in_ready, blk_valid, blk_last, blk_count, blk_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b0);
        vectors++;
        if ({blk_valid, blk_last} !== 2'b10 || blk_data !== 128'h0102030405060708090a0b0c0d0e0f10) begin
            miscompares++;
            $display("FAIL mid_reset_blk: got vld=%b last=%b data=%h want 1 0 0102030405060708090a0b0c0d0e0f10", blk_valid, blk_last, blk_data);
        end
        handoff();
        vectors++;
        if (blk_count !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_reset_cnt: got %h want 0001", blk_count);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        force dut.blk_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.blk_count;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        handoff();
        vectors++;
        if (blk_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL count_wrap: got %h want 0000", blk_count);
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_exact_multiple();
        test_partial();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
